// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared helpers for the LCE request router
package bp_me_pkg;

    // Width of a counter that must hold 0..credits inclusive.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    // Number of bits needed to name one CCE (at least 1 so ports stay legal).
    function automatic int stripe_bits(input int num_cce);
        return (num_cce > 1) ? $clog2(num_cce) : 1;
    endfunction

    // Destination CCE for a physical address: the block-number bits just above
    // the block offset, masked to the CCE count (num_cce is a power of two).
    function automatic logic [31:0] stripe_sel(input logic [63:0] paddr,
                                               input int block_offset,
                                               input int num_cce);
        logic [63:0] shifted;
        shifted = paddr >> block_offset;
        return 32'(shifted & 64'(num_cce - 1));
    endfunction

    localparam int default_credits_lp      = 4;
    localparam int default_credit_width_lp = credit_width(default_credits_lp);

endpackage

// File: rtl/bp_me_rr_arb.sv
// rtl/bp_me_rr_arb.sv - N-way round-robin arbiter with pointer register
module bp_me_rr_arb #(
    parameter int n_p    = 4,
    localparam int id_w_lp = (n_p > 1) ? $clog2(n_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [n_p-1:0]     req_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [n_p-1:0]     grant_o,
    output logic [id_w_lp-1:0] grant_id_o
);
    logic [id_w_lp-1:0] ptr_r;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        v_o        = 1'b0;
        grant_id_o = ptr_r;
        idx        = 0;
        for (int off = 0; off < n_p; off++) begin
            idx = int'(ptr_r) + off;
            if (idx >= n_p) idx = idx - n_p;
            if (!v_o && req_i[id_w_lp'(idx)]) begin
                v_o        = 1'b1;
                grant_id_o = id_w_lp'(idx);
            end
        end
        for (int k = 0; k < n_p; k++) begin
            grant_o[k] = v_o && (grant_id_o == id_w_lp'(k));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (yumi_i) begin
            ptr_r <= (grant_id_o == id_w_lp'(n_p - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small circular FIFO with registered ready
module bsg_fifo_1r1w_small #(
    parameter int width_p            = 8,
    parameter int els_p              = 2,
    parameter int ready_THEN_valid_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] mem_r;
    logic [ptr_w_lp-1:0]           wptr_r, rptr_r;
    logic [cnt_w_lp-1:0]           count_r, count_n;
    logic                          full_r;
    logic                          enq, deq;

    // Ready-then-valid callers only see the registered full state; the other
    // mode lets a same-cycle dequeue free a slot.
    if (ready_THEN_valid_p != 0) begin : g_rtv
        assign ready_o = ~full_r;
    end else begin : g_vtr
        assign ready_o = ~full_r | yumi_i;
    end

    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign count_n = count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
        end else begin
            if (enq) wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
            if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
            count_r <= count_n;
            full_r  <= (count_n == cnt_w_lp'(els_p));
        end
    end

endmodule

// File: rtl/bp_me_lce_req_router.sv
// rtl/bp_me_lce_req_router.sv - LCE-to-CCE request router with striping and credits
module bp_me_lce_req_router
    import bp_me_pkg::*;
#(
    parameter int num_lce_p            = 4,
    parameter int num_cce_p            = 2,
    parameter int req_width_p          = 64,
    parameter int addr_lsb_p           = 8,
    parameter int block_offset_width_p = 6,
    parameter int fifo_els_p           = 2,
    parameter int credits_p            = 4,
    localparam int cw_lp               = credit_width(credits_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_lce_p-1:0][req_width_p-1:0] lce_req_i,
    input  logic [num_lce_p-1:0]                  lce_req_v_i,
    output logic [num_lce_p-1:0]                  lce_req_ready_o,
    output logic [num_cce_p-1:0][req_width_p-1:0] cce_req_o,
    output logic [num_cce_p-1:0]                  cce_req_v_o,
    input  logic [num_cce_p-1:0]                  cce_req_ready_i,
    input  logic [num_cce_p-1:0]                  cce_credit_return_i,
    output logic [num_cce_p-1:0][cw_lp-1:0]       credit_count_o,
    output logic                                  error_o
);
    localparam int lce_id_w_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int dest_w_lp   = stripe_bits(num_cce_p);

    logic [num_lce_p-1:0][req_width_p-1:0] head;
    logic [num_lce_p-1:0]                  head_v;
    logic [num_lce_p-1:0]                  deq;
    logic [num_lce_p-1:0][dest_w_lp-1:0]   dest;

    logic [num_cce_p-1:0][num_lce_p-1:0]   req_vec;
    logic [num_cce_p-1:0][num_lce_p-1:0]   grant;
    logic [num_cce_p-1:0][lce_id_w_lp-1:0] win;
    logic [num_cce_p-1:0]                  arb_v;
    logic [num_cce_p-1:0]                  xfer;
    logic [num_cce_p-1:0][cw_lp-1:0]       credit_r;
    logic                                  error_r;

    for (genvar i = 0; i < num_lce_p; i++) begin : g_lce
        bsg_fifo_1r1w_small #(
            .width_p            (req_width_p),
            .els_p              (fifo_els_p),
            .ready_THEN_valid_p (1)
        ) fifo (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .v_i       (lce_req_v_i[i]),
            .data_i    (lce_req_i[i]),
            .ready_o   (lce_req_ready_o[i]),
            .v_o       (head_v[i]),
            .data_o    (head[i]),
            .yumi_i    (deq[i])
        );
    end

    always_comb begin
        for (int i = 0; i < num_lce_p; i++) begin
            dest[i] = dest_w_lp'(stripe_sel(64'(head[i] >> addr_lsb_p),
                                            block_offset_width_p, num_cce_p));
        end
        for (int c = 0; c < num_cce_p; c++) begin
            for (int i = 0; i < num_lce_p; i++) begin
                req_vec[c][i] = head_v[i] && (dest[i] == dest_w_lp'(c));
            end
        end
    end

    for (genvar c = 0; c < num_cce_p; c++) begin : g_cce
        bp_me_rr_arb #(.n_p(num_lce_p)) arb (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .req_i      (req_vec[c]),
            .yumi_i     (xfer[c]),
            .v_o        (arb_v[c]),
            .grant_o    (grant[c]),
            .grant_id_o (win[c])
        );
        // Valid depends only on heads, pointer and credits, never on ready.
        assign cce_req_v_o[c] = arb_v[c] && (credit_r[c] != '0);
        assign cce_req_o[c]   = head[win[c]];
        assign xfer[c]        = cce_req_v_o[c] & cce_req_ready_i[c];
    end

    // Each head targets exactly one CCE, so at most one grant can pop it.
    always_comb begin
        deq = '0;
        for (int c = 0; c < num_cce_p; c++) begin
            deq = deq | (grant[c] & {num_lce_p{xfer[c]}});
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < num_cce_p; c++) credit_r[c] <= cw_lp'(credits_p);
            error_r <= 1'b0;
        end else begin
            for (int c = 0; c < num_cce_p; c++) begin
                if (xfer[c] && !cce_credit_return_i[c]) begin
                    credit_r[c] <= credit_r[c] - 1'b1;
                end else if (!xfer[c] && cce_credit_return_i[c]) begin
                    if (credit_r[c] == cw_lp'(credits_p)) error_r <= 1'b1;
                    else                                  credit_r[c] <= credit_r[c] + 1'b1;
                end
            end
        end
    end

    assign credit_count_o = credit_r;
    assign error_o        = error_r;

endmodule

// File: tb/tb_bp_me_lce_req_router.sv
// tb/tb_bp_me_lce_req_router.sv - randomized bench with queue-based reference model
module tb_bp_me_lce_req_router;
    localparam int NL = 4, NC = 2, W = 32, ADDR_LSB = 8, BO = 6, ELS = 2, CR = 4;
    localparam int CW = $clog2(CR + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NL-1:0][W-1:0]  lce_req;
    logic [NL-1:0]         lce_v, lce_rdy;
    logic [NC-1:0][W-1:0]  cce_req;
    logic [NC-1:0]         cce_v, cce_rdy, cret;
    logic [NC-1:0][CW-1:0] ccount;
    logic                  err;

    bp_me_lce_req_router #(
        .num_lce_p(NL), .num_cce_p(NC), .req_width_p(W), .addr_lsb_p(ADDR_LSB),
        .block_offset_width_p(BO), .fifo_els_p(ELS), .credits_p(CR)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .lce_req_i(lce_req), .lce_req_v_i(lce_v), .lce_req_ready_o(lce_rdy),
        .cce_req_o(cce_req), .cce_req_v_o(cce_v), .cce_req_ready_i(cce_rdy),
        .cce_credit_return_i(cret), .credit_count_o(ccount), .error_o(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mq [NL][$];
    int rr_m [NC];
    int cr_m [NC];
    bit err_m;
    int seq = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [W-1:0] r);
        return int'((r >> (ADDR_LSB + BO)) % NC);
    endfunction

    function automatic logic [W-1:0] mk(input int lce, input logic [23:0] paddr);
        logic [7:0] tag;
        tag = {2'(lce), 6'(seq)};
        seq++;
        return {paddr, tag};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mq[i].delete();
        for (int c = 0; c < NC; c++) begin
            rr_m[c] = 0;
            cr_m[c] = CR;
        end
        err_m = 1'b0;
    endtask

    // Called just after a falling edge: check outputs against the model,
    // drive this cycle's inputs, advance the model, wait for the next fall.
    task automatic step(input logic [NL-1:0] v, input logic [NL-1:0][W-1:0] d,
                        input logic [NC-1:0] rdy, input logic [NC-1:0] ret);
        int win [NC];
        bit ev [NC];
        int sz [NL];
        for (int c = 0; c < NC; c++) begin
            ev[c] = 1'b0;
            win[c] = 0;
            if (cr_m[c] > 0) begin
                for (int k = 0; k < NL; k++) begin
                    int i;
                    i = (rr_m[c] + k) % NL;
                    if (!ev[c] && mq[i].size() > 0 && dest_of(mq[i][0]) == c) begin
                        ev[c] = 1'b1;
                        win[c] = i;
                    end
                end
            end
            check($sformatf("cce_v[%0d]", c), 64'(cce_v[c]), 64'(ev[c]));
            if (ev[c]) check($sformatf("cce_req[%0d]", c), 64'(cce_req[c]), 64'(mq[win[c]][0]));
            check($sformatf("credit[%0d]", c), 64'(ccount[c]), 64'(cr_m[c]));
        end
        for (int i = 0; i < NL; i++) begin
            sz[i] = mq[i].size();
            check($sformatf("lce_rdy[%0d]", i), 64'(lce_rdy[i]), 64'(sz[i] < ELS));
        end
        check("error", 64'(err), 64'(err_m));

        lce_v = v; lce_req = d; cce_rdy = rdy; cret = ret;

        for (int c = 0; c < NC; c++) begin
            bit t;
            t = ev[c] && rdy[c];
            if (t) begin
                void'(mq[win[c]].pop_front());
                rr_m[c] = (win[c] + 1) % NL;
            end
            if (ret[c] && !t && cr_m[c] == CR) err_m = 1'b1;
            else cr_m[c] = cr_m[c] + int'(ret[c]) - int'(t);
        end
        for (int i = 0; i < NL; i++) begin
            if (v[i] && sz[i] < ELS) mq[i].push_back(d[i]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [NC-1:0] rdy, input logic [NC-1:0] ret);
        step('0, '0, rdy, ret);
    endtask

    // Return credits until every port is full again and buffers drain.
    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            logic [NC-1:0] r;
            for (int c = 0; c < NC; c++) r[c] = (cr_m[c] < CR);
            idle('1, r);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lce_v = '0; cce_rdy = '0; cret = '0;
        #1;
        check("rst cce_v", 64'(cce_v), 64'(0));
        check("rst lce_rdy", 64'(lce_rdy), 64'({NL{1'b1}}));
        check("rst credit0", 64'(ccount[0]), 64'(CR));
        check("rst credit1", 64'(ccount[1]), 64'(CR));
        check("rst error", 64'(err), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NL-1:0][W-1:0] d;
        lce_req = '0; lce_v = '0; cce_rdy = '0; cret = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Striping: four consecutive blocks alternate between the two CCEs.
        for (int i = 0; i < NL; i++) d[i] = mk(i, 24'(i * 'h40));
        step('1, d, '1, '0);
        check("stripe first c0 pending", 64'(mq[0].size()), 64'(1));
        idle('1, '0);
        check("stripe cce0 head", 64'(cce_req[0]), 64'(d[2]));
        check("stripe cce1 head", 64'(cce_req[1]), 64'(d[3]));
        drain();

        // Fairness: everyone streams to CCE0, credits recycled each cycle.
        for (int n = 0; n < 24; n++) begin
            logic [NC-1:0] r;
            for (int i = 0; i < NL; i++) d[i] = mk(i, 24'($urandom) & 24'hFFFFBF);
            for (int c = 0; c < NC; c++) r[c] = (cr_m[c] < CR);
            step('1, d, '1, r);
        end
        drain();

        // Credit exhaustion: six requests to CCE0, no returns.
        for (int i = 0; i < NL; i++) d[i] = mk(i, 24'h000100);
        step('1, d, '1, '0);
        for (int i = 0; i < NL; i++) d[i] = mk(i, 24'h000200);
        step(4'b0011, d, '1, '0);
        repeat (8) idle('1, '0);
        check("exhaust credit0", 64'(ccount[0]), 64'(0));
        check("exhaust cce_v0", 64'(cce_v[0]), 64'(0));
        idle('1, 2'b01);
        idle('1, '0);
        check("one return credit0", 64'(ccount[0]), 64'(0));
        drain();

        // Transfer and return in the same cycle at full credit.
        d[0] = mk(0, 24'h000000);
        step(4'b0001, d, '1, '0);
        idle('1, 2'b01);
        check("simul credit0", 64'(ccount[0]), 64'(CR));
        check("simul no error", 64'(err), 64'(0));

        // Overflow: return at full count saturates and sets the sticky flag.
        idle('1, 2'b01);
        repeat (3) idle('1, '0);
        check("overflow credit0", 64'(ccount[0]), 64'(CR));
        check("overflow error", 64'(err), 64'(1));
        do_reset();

        // Head-of-line: LCE0 sends to blocked CCE1, then to CCE0.
        d[0] = mk(0, 24'h000040);
        step(4'b0001, d, 2'b01, '0);
        d[0] = mk(0, 24'h000000);
        step(4'b0001, d, 2'b01, '0);
        d[0] = mk(0, 24'h000080);
        step(4'b0001, d, 2'b01, '0);
        repeat (3) idle(2'b01, '0);
        check("hol ready0 low", 64'(lce_rdy[0]), 64'(0));
        check("hol cce_v0 blocked", 64'(cce_v[0]), 64'(0));
        idle(2'b11, '0);
        check("hol ready0 back", 64'(lce_rdy[0]), 64'(1));
        drain();

        // Randomized traffic with a reset landing on full buffers mid-run.
        for (int n = 0; n < 1500; n++) begin
            logic [NL-1:0] v;
            logic [NC-1:0] rdy, r;
            v = NL'($urandom);
            for (int i = 0; i < NL; i++) d[i] = mk(i, 24'($urandom));
            for (int c = 0; c < NC; c++) begin
                rdy[c] = ($urandom % 4) != 0;
                r[c]   = (cr_m[c] < CR) && ($urandom % 3 == 0);
            end
            if (n >= 700 && n < 706) rdy = '0;
            step(v, d, rdy, r);
            if (n == 705) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
